// File: rtl/anyedge_detect.sv
// rtl/anyedge_detect.sv - registered per-bit any-edge detector
module anyedge_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] anyedge
);

  logic [WIDTH-1:0] din_q;

  // Remember last sampled bus value and flag every lane whose value changed since then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q   <= '0;
      anyedge <= '0;
    end else begin
      din_q   <= din;
      anyedge <= din ^ din_q;
    end
  end

endmodule

// File: tb/tb_anyedge_detect.sv
// tb/tb_anyedge_detect.sv - directed and random self-checking bench for anyedge_detect
module tb_anyedge_detect;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] anyedge;

  int checks;
  int errors;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] exp_v;
  logic [WIDTH-1:0] held;

  anyedge_detect #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .anyedge (anyedge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive din, let one rising edge sample it, then check anyedge shortly after that edge
  task automatic step(input string tag, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] expv);
    din = d;
    @(posedge clk);
    #1;
    check(tag, anyedge, expv);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    din    = '0;

    // 1. Reset held while din toggles: output stays clear
    for (int i = 0; i < 4; i++) begin
      din = (i % 2 == 0) ? 8'hFF : 8'h5A;
      @(posedge clk);
      #1;
      check("reset_hold", anyedge, 8'h00);
    end
    din   = 8'h00;
    rst_n = 1'b1;
    step("release_zero_a", 8'h00, 8'h00);
    step("release_zero_b", 8'h00, 8'h00);

    // 2. Rising edge on bit 0, held 4 cycles
    step("rise_k",   8'h01, 8'h01);
    step("rise_k1",  8'h01, 8'h00);
    step("rise_k2",  8'h01, 8'h00);
    step("rise_k3",  8'h01, 8'h00);

    // 3. Falling edge on bit 0
    step("fall_k",   8'h00, 8'h01);
    step("fall_k1",  8'h00, 8'h00);

    // 4. Multi-bit rise, hold 2, then fall
    step("multi_rise",   8'h06, 8'h06);
    step("multi_hold",   8'h06, 8'h00);
    step("multi_fall",   8'h00, 8'h06);
    step("multi_after",  8'h00, 8'h00);

    // 5. Toggle every cycle, then stop
    step("tog_0", 8'hFF, 8'hFF);
    step("tog_1", 8'h00, 8'hFF);
    step("tog_2", 8'hFF, 8'hFF);
    step("tog_3", 8'h00, 8'hFF);
    step("tog_4", 8'hFF, 8'hFF);
    step("tog_5", 8'h00, 8'hFF);
    step("tog_stop", 8'h00, 8'h00);

    // No combinational path: changing din between edges must not move anyedge
    step("comb_base", 8'h3C, 8'h3C);
    held = anyedge;
    din  = 8'hC3;
    #2;
    check("no_comb_path", anyedge, 8'h3C);
    step("comb_next", 8'hC3, 8'hFF);

    // 6. Random soak against golden model, with an async reset pulse mid-run
    prev = 8'hC3;
    for (int k = 0; k < 240; k++) begin
      if (k == 120) begin
        step("pre_rst_pulse", ~prev, 8'hFF);
        prev = ~prev;
        rst_n = 1'b0;
        #1;
        check("async_clear", anyedge, 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_soak", anyedge, 8'h00);
        rst_n = 1'b1;
        prev  = 8'h00;
      end
      din   = 8'($urandom);
      exp_v = din ^ prev;
      prev  = din;
      step("soak", din, exp_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
